// File: rtl/arbitro_sumador_resta.sv
// arbitro_sumador_resta
//   Round-robin front end for one shared 32-bit ripple adder/subtractor.
//   Two requesters hand in (a, b, op) over valid/ready. The winner's operands
//   are registered, evaluated by sumador_resta for one cycle, and the result
//   and flags are returned on a held response channel tagged with the ID.
//
//   Ports
//     clk, rst               clock (rising edge), async active-high reset
//     reqN_valid/ready       request handshake, N = 0,1 (ready only in IDLE)
//     reqN_a, reqN_b, reqN_op operands; op 0 = a+b, 1 = a-b
//     resp_valid/ready       response handshake
//     resp_id                requester that issued the result
//     resp_result            sum/difference (saturated when enabled)
//     resp_carry             raw adder carry-out (sub: 1 = no borrow)
//     resp_ovf               signed overflow
//     resp_zero              final resp_result == 0
//
//   Build option
//     ARBITRO_SUMRES_SAT_EN  saturate resp_result on signed overflow.

// One bit cell of the ripple chain.
module sumador_resta_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// Ripple adder: b is expected already conditionally inverted by the caller,
// ci carries the +1 of two's complement for subtraction.
module sumador_resta #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);
  logic [W:0] c;

  assign c[0] = ci;
  assign co   = c[W];

  for (genvar i = 0; i < W; i++) begin : g_bit
    sumador_resta_fa u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end
endmodule

module arbitro_sumador_resta #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_op,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_op,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_id,
  output logic [W-1:0] resp_result,
  output logic         resp_carry,
  output logic         resp_ovf,
  output logic         resp_zero
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t       state;
  logic         last;     // requester granted most recently
  logic [W-1:0] a_q, b_q;
  logic         op_q, id_q;

  logic         g0, g1;
  logic [W-1:0] bin, sum, fin;
  logic         co, ovf;

  // Grants are mutually exclusive: on contention, last picks the other side.
  assign g0 = req0_valid & (~req1_valid | last);
  assign g1 = req1_valid & (~req0_valid | ~last);

  // Readies are combinational from IDLE but forced low during reset.
  assign req0_ready = ~rst & (state == IDLE) & g0;
  assign req1_ready = ~rst & (state == IDLE) & g1;

  assign bin = op_q ? ~b_q : b_q;

  sumador_resta #(.W(W)) u_add (
    .a  (a_q),
    .b  (bin),
    .ci (op_q),
    .s  (sum),
    .co (co)
  );

  assign ovf = (a_q[W-1] == bin[W-1]) & (sum[W-1] != a_q[W-1]);

`ifdef ARBITRO_SUMRES_SAT_EN
  // Clamp toward the sign of a: positive overflow -> max, negative -> min.
  assign fin = ovf ? (a_q[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}})
                   : sum;
`else
  assign fin = sum;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last        <= 1'b1;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 1'b0;
      id_q        <= 1'b0;
      resp_valid  <= 1'b0;
      resp_id     <= 1'b0;
      resp_result <= '0;
      resp_carry  <= 1'b0;
      resp_ovf    <= 1'b0;
      resp_zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (g0 | g1) begin
            a_q   <= g1 ? req1_a  : req0_a;
            b_q   <= g1 ? req1_b  : req0_b;
            op_q  <= g1 ? req1_op : req0_op;
            id_q  <= g1;
            last  <= g1;
            state <= EXEC;
          end
        end
        EXEC: begin
          resp_valid  <= 1'b1;
          resp_id     <= id_q;
          resp_result <= fin;
          resp_carry  <= co;
          resp_ovf    <= ovf;
          resp_zero   <= (fin == '0);
          state       <= RESP;
        end
        RESP: begin
          // Always pass back through IDLE before the next grant.
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_arbitro_sumador_resta.sv
module tb_arbitro_sumador_resta;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_op;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_op;
  logic [31:0] req1_a, req1_b;
  logic        resp_valid, resp_ready, resp_id;
  logic [31:0] resp_result;
  logic        resp_carry, resp_ovf, resp_zero;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  arbitro_sumador_resta #(.W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_op     (req0_op),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_op     (req1_op),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_result (resp_result),
    .resp_carry  (resp_carry),
    .resp_ovf    (resp_ovf),
    .resp_zero   (resp_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single operation from an idle block, with resp_ready low until checked.
  task automatic do_op(input string tag, input bit id, input logic [31:0] a,
                       input logic [31:0] b, input bit op, input logic [31:0] er,
                       input bit ec, input bit eo, input bit ez);
    if (id) begin req1_valid = 1; req1_a = a; req1_b = b; req1_op = op; end
    else    begin req0_valid = 1; req0_a = a; req0_b = b; req0_op = op; end
    #1;
    chk({tag, ".ready"}, id ? req1_ready : req0_ready, 1);
    step();
    req0_valid = 0;
    req1_valid = 0;
    chk({tag, ".exec_valid"}, resp_valid, 0);
    step();
    chk({tag, ".valid"},  resp_valid,  1);
    chk({tag, ".id"},     resp_id,     id);
    chk({tag, ".result"}, resp_result, er);
    chk({tag, ".carry"},  resp_carry,  ec);
    chk({tag, ".ovf"},    resp_ovf,    eo);
    chk({tag, ".zero"},   resp_zero,   ez);
    resp_ready = 1;
    step();
    resp_ready = 0;
    chk({tag, ".done"}, resp_valid, 0);
  endtask

  logic [31:0] sat_exp;
  bit          exp_id [4] = '{0, 1, 0, 1};

  initial begin
    int n;
    rst = 1; resp_ready = 0;
    req0_valid = 1; req0_a = 0; req0_b = 0; req0_op = 0;
    req1_valid = 1; req1_a = 0; req1_b = 0; req1_op = 0;
    #2;
    chk("rst.ready0", req0_ready, 0);
    chk("rst.ready1", req1_ready, 0);
    chk("rst.valid",  resp_valid, 0);
    chk("rst.result", resp_result, 0);
    chk("rst.flags",  {resp_id, resp_carry, resp_ovf, resp_zero}, 0);
    req0_valid = 0; req1_valid = 0;
    step(); step();
    rst = 0;
    step();

    do_op("add0",  0, 32'd3, 32'd4, 0, 32'd7, 0, 0, 0);
    do_op("sub1",  1, 32'd5, 32'd7, 1, 32'hFFFF_FFFE, 0, 0, 0);
    do_op("wrap",  0, 32'hFFFF_FFFF, 32'd1, 0, 32'd0, 1, 0, 1);
`ifdef ARBITRO_SUMRES_SAT_EN
    sat_exp = 32'h7FFF_FFFF;
`else
    sat_exp = 32'h8000_0000;
`endif
    // Issued by requester 1 so the pointer favours requester 0 next.
    do_op("sovf",  1, 32'h7FFF_FFFF, 32'd1, 0, sat_exp, 0, 1, 0);

    // Contention: req0 10+1=11, req1 20-5=15.
    req0_valid = 1; req0_a = 32'd10; req0_b = 32'd1; req0_op = 0;
    req1_valid = 1; req1_a = 32'd20; req1_b = 32'd5; req1_op = 1;
    resp_ready = 1;
    n = 0;
    for (int cyc = 0; cyc < 30 && n < 4; cyc++) begin
      step();
      if (resp_valid) begin
        chk($sformatf("cont.id%0d", n), resp_id, exp_id[n]);
        chk($sformatf("cont.res%0d", n), resp_result, exp_id[n] ? 32'd15 : 32'd11);
        n++;
        if (n == 4) resp_ready = 0;
      end
    end
    chk("cont.count", n, 4);

    // Backpressure: the 4th response (id 1) is held for 5 cycles.
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp.valid",  resp_valid, 1);
      chk("bp.id",     resp_id, 1);
      chk("bp.result", resp_result, 32'd15);
      chk("bp.ready",  {req0_ready, req1_ready}, 0);
    end
    resp_ready = 1;
    step();
    resp_ready = 0;
    chk("bp.idle_ready", {req0_ready, req1_ready}, 2'b10);
    step();
    chk("ex.valid", resp_valid, 0);

    // Reset while in EXEC.
    rst = 1;
    #1;
    chk("mrst.valid", resp_valid, 0);
    chk("mrst.ready", {req0_ready, req1_ready}, 0);
    chk("mrst.data",  {resp_id, resp_carry, resp_ovf, resp_zero} | resp_result, 0);
    step();
    rst = 0;
    #1;
    chk("post.ready", {req0_ready, req1_ready}, 2'b10);
    step();
    chk("post.exec", resp_valid, 0);
    step();
    chk("post.valid",  resp_valid, 1);
    chk("post.id",     resp_id, 0);
    chk("post.result", resp_result, 32'd11);

    req0_valid = 0; req1_valid = 0;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
